// File: rtl/basic_ipv4_router_pkg.sv
// router_pkg: shared types, header offsets and match helpers for the IPv4 router
package router_pkg;
   typedef enum logic [2:0] {ACT_DROP = 3'd0, ACT_FORWARD = 3'd1} action_e;
   typedef struct packed {
      logic        valid;
      logic [31:0] prefix;
      logic [5:0]  prefix_len;
      logic [2:0]  action;
      logic [47:0] dst_mac;
      logic [8:0]  port;
   } route_entry_t;
   typedef struct packed {
      logic [5:0]  prefix_len;
      logic [2:0]  action;
      logic [47:0] dst_mac;
      logic [8:0]  port;
   } route_hit_t;
   localparam int DST_MAC_LSB = 0;
   localparam int SRC_MAC_LSB = 48;
   localparam int ETYPE_LSB = 96;
   localparam int TTL_LSB = 176;
   localparam int CSUM_LSB = 192;
   localparam int DST_IP_LSB = 240;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   function automatic logic prefix_match(logic v, logic [31:0] pfx, logic [5:0] len, logic [31:0] ip);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << (6'd32 - len);
      return v && len <= 6'd32 && ((ip ^ pfx) & m) == 32'd0;
   endfunction
   // strict compare keeps the lower index on equal prefix lengths
   function automatic logic take(logic c_hit, logic [5:0] c_len, logic b_hit, logic [5:0] b_len);
      return c_hit && (!b_hit || c_len > b_len);
   endfunction
   function automatic logic [15:0] csum_ttl_dec(logic [15:0] c);
      logic [16:0] s;
      s = {1'b0, c} + 17'h0100;
      return s[15:0] + {15'd0, s[16]};
   endfunction
endpackage

// File: rtl/basic_ipv4_router_if.sv
// router_axis_if: AXI4-Stream bundle with egress destination
interface router_axis_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [8:0]              tdest;
   modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
   modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/basic_ipv4_router_lpm_lookup.sv
// lpm_lookup: routing table with a three-stage pipelined longest-prefix match (TABLE_SIZE multiple of 256)
module lpm_lookup
   import router_pkg::*;
#(
   parameter int TABLE_SIZE = 1024
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          wr_en,
   input  logic [$clog2(TABLE_SIZE)-1:0] wr_addr,
   input  route_entry_t                  wr_entry,
   input  logic                          key_valid,
   input  logic [31:0]                   key_ip,
   output logic                          rsp_valid,
   output logic                          rsp_hit,
   output logic [2:0]                    rsp_action,
   output logic [47:0]                   rsp_dst_mac,
   output logic [8:0]                    rsp_port
);
   localparam int GA = 32;
   localparam int NA = TABLE_SIZE / GA;
   localparam int GB = 8;
   localparam int NB = NA / GB;
   logic [TABLE_SIZE-1:0] vld;
   logic [31:0]           pfx [TABLE_SIZE];
   route_hit_t            ent [TABLE_SIZE];
   logic [NA-1:0]         a_hit_c, a_hit_q;
   route_hit_t            a_c [NA];
   route_hit_t            a_q [NA];
   logic [NB-1:0]         b_hit_c, b_hit_q;
   route_hit_t            b_c [NB];
   route_hit_t            b_q [NB];
   logic                  c_hit;
   route_hit_t            c_r;
   logic [1:0]            v;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         vld <= '0;
         v <= '0;
         rsp_valid <= 1'b0;
      end else begin
         if (wr_en) vld[wr_addr] <= wr_entry.valid;
         {rsp_valid, v} <= {v, key_valid};
      end
   // whole winning entries travel down the pipe, so a concurrent write never yields a mixed result
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         pfx[wr_addr] <= wr_entry.prefix;
         ent[wr_addr] <= '{wr_entry.prefix_len, wr_entry.action, wr_entry.dst_mac, wr_entry.port};
      end
      a_hit_q <= a_hit_c;
      a_q <= a_c;
      b_hit_q <= b_hit_c;
      b_q <= b_c;
      rsp_hit <= c_hit;
      rsp_action <= c_r.action;
      rsp_dst_mac <= c_r.dst_mac;
      rsp_port <= c_r.port;
   end
   always_comb begin
      a_hit_c = '0;
      for (int g = 0; g < NA; g++) begin
         a_c[g] = '0;
         for (int i = 0; i < GA; i++)
            if (take(prefix_match(vld[g*GA+i], pfx[g*GA+i], ent[g*GA+i].prefix_len, key_ip),
                     ent[g*GA+i].prefix_len, a_hit_c[g], a_c[g].prefix_len)) begin
               a_hit_c[g] = 1'b1;
               a_c[g] = ent[g*GA+i];
            end
      end
   end
   always_comb begin
      b_hit_c = '0;
      for (int g = 0; g < NB; g++) begin
         b_c[g] = '0;
         for (int i = 0; i < GB; i++)
            if (take(a_hit_q[g*GB+i], a_q[g*GB+i].prefix_len, b_hit_c[g], b_c[g].prefix_len)) begin
               b_hit_c[g] = 1'b1;
               b_c[g] = a_q[g*GB+i];
            end
      end
   end
   always_comb begin
      c_hit = 1'b0;
      c_r = '0;
      for (int g = 0; g < NB; g++)
         if (take(b_hit_q[g], b_q[g].prefix_len, c_hit, c_r.prefix_len)) begin
            c_hit = 1'b1;
            c_r = b_q[g];
         end
   end
endmodule

// File: rtl/basic_ipv4_router.sv
// basic_ipv4_router: AXI4-Stream IPv4 router with LPM lookup, header rewrite and statistics
module basic_ipv4_router
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int TABLE_SIZE = 1024
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   router_axis_if.slave                  s_axis,
   router_axis_if.master                 m_axis,
   input  logic                          table_write_enable,
   input  logic [$clog2(TABLE_SIZE)-1:0] table_write_addr,
   input  logic                          table_entry_valid,
   input  logic [31:0]                   table_entry_prefix,
   input  logic [5:0]                    table_entry_prefix_len,
   input  logic [2:0]                    table_entry_action,
   input  logic [47:0]                   table_entry_dst_mac,
   input  logic [8:0]                    table_entry_egress_port,
   output logic [31:0]                   packet_count,
   output logic [31:0]                   forwarded_count,
   output logic [31:0]                   dropped_count
);
   typedef enum logic [2:0] {IDLE, LOOKUP, EMIT, PASS, DROP, DROP_REST} state_e;
   state_e                  state;
   logic [DATA_WIDTH-1:0]   beat_q, odata_q, rw_data;
   logic [DATA_WIDTH/8-1:0] keep_q, okeep_q;
   logic                    last_q, olast_q, ovalid_q, rdy_q, fwd, s_hs, pass, key_valid;
   logic [8:0]              odest_q;
   logic                    rsp_valid, rsp_hit;
   logic [2:0]              rsp_action;
   logic [47:0]             rsp_dst_mac;
   logic [8:0]              rsp_port;
   route_entry_t            wr_entry;
   assign wr_entry = '{table_entry_valid, table_entry_prefix, table_entry_prefix_len,
                       table_entry_action, table_entry_dst_mac, table_entry_egress_port};
   assign s_hs = s_axis.tvalid && s_axis.tready;
   assign pass = state == PASS;
   assign key_valid = state == IDLE && s_hs;
   // continuation beats bypass the output registers with backpressure wired straight through
   assign s_axis.tready = pass ? m_axis.tready : rdy_q;
   assign m_axis.tvalid = pass ? s_axis.tvalid : ovalid_q;
   assign m_axis.tdata = pass ? s_axis.tdata : odata_q;
   assign m_axis.tkeep = pass ? s_axis.tkeep : okeep_q;
   assign m_axis.tlast = pass ? s_axis.tlast : olast_q;
   assign m_axis.tdest = odest_q;
   lpm_lookup #(.TABLE_SIZE(TABLE_SIZE)) u_lpm (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .wr_en       (table_write_enable),
      .wr_addr     (table_write_addr),
      .wr_entry    (wr_entry),
      .key_valid   (key_valid),
      .key_ip      (s_axis.tdata[DST_IP_LSB +: 32]),
      .rsp_valid   (rsp_valid),
      .rsp_hit     (rsp_hit),
      .rsp_action  (rsp_action),
      .rsp_dst_mac (rsp_dst_mac),
      .rsp_port    (rsp_port)
   );
   always_comb begin
      fwd = beat_q[ETYPE_LSB +: 16] == ETHERTYPE_IPV4 && rsp_hit && rsp_action == ACT_FORWARD
            && beat_q[TTL_LSB +: 8] > 8'd1;
      rw_data = beat_q;
      rw_data[DST_MAC_LSB +: 48] = rsp_dst_mac;
      rw_data[SRC_MAC_LSB +: 48] = beat_q[DST_MAC_LSB +: 48];
      rw_data[TTL_LSB +: 8] = beat_q[TTL_LSB +: 8] - 8'd1;
      rw_data[CSUM_LSB +: 16] = csum_ttl_dec(beat_q[CSUM_LSB +: 16]);
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state <= IDLE;
         rdy_q <= 1'b0;
         ovalid_q <= 1'b0;
         odata_q <= '0;
         okeep_q <= '0;
         olast_q <= 1'b0;
         odest_q <= '0;
         beat_q <= '0;
         keep_q <= '0;
         last_q <= 1'b0;
         packet_count <= '0;
         forwarded_count <= '0;
         dropped_count <= '0;
      end else
         case (state)
            IDLE: begin
               rdy_q <= !s_hs;
               if (s_hs) begin
                  beat_q <= s_axis.tdata;
                  keep_q <= s_axis.tkeep;
                  last_q <= s_axis.tlast;
                  state <= LOOKUP;
               end
            end
            LOOKUP:
               if (rsp_valid) begin
                  packet_count <= packet_count + 32'd1;
                  if (fwd) begin
                     forwarded_count <= forwarded_count + 32'd1;
                     ovalid_q <= 1'b1;
                     odata_q <= rw_data;
                     okeep_q <= keep_q;
                     olast_q <= last_q;
                     odest_q <= rsp_port;
                     state <= EMIT;
                  end else begin
                     dropped_count <= dropped_count + 32'd1;
                     state <= DROP;
                  end
               end
            EMIT:
               if (m_axis.tready) begin
                  ovalid_q <= 1'b0;
                  rdy_q <= 1'b1;
                  state <= olast_q ? IDLE : PASS;
               end
            PASS: if (s_hs && s_axis.tlast) state <= IDLE;
            DROP: begin
               rdy_q <= 1'b1;
               state <= last_q ? IDLE : DROP_REST;
            end
            DROP_REST: if (s_hs && s_axis.tlast) state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_basic_ipv4_router.sv
// tb_basic_ipv4_router: directed self-checking bench for the IPv4 router
module tb_basic_ipv4_router;
   localparam int DW = 512;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;
   router_axis_if #(.DATA_WIDTH(DW)) s_if ();
   router_axis_if #(.DATA_WIDTH(DW)) m_if ();
   logic        twe = 1'b0;
   logic [9:0]  twa = '0;
   logic        tv = 1'b0;
   logic [31:0] tp = '0;
   logic [5:0]  tl = '0;
   logic [2:0]  ta = '0;
   logic [47:0] tm = '0;
   logic [8:0]  tport = '0;
   logic [31:0] pc, fc, dc;
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] oq_d [$];
   logic [8:0]    oq_t [$];
   logic          oq_l [$];
   logic [DW-1:0] prev_d;
   logic [8:0]    prev_t;
   logic          prev_l;
   logic          stalled = 1'b0;

   basic_ipv4_router #(.DATA_WIDTH(DW), .TABLE_SIZE(1024)) dut (
      .aclk                    (aclk),
      .aresetn                 (aresetn),
      .s_axis                  (s_if),
      .m_axis                  (m_if),
      .table_write_enable      (twe),
      .table_write_addr        (twa),
      .table_entry_valid       (tv),
      .table_entry_prefix      (tp),
      .table_entry_prefix_len  (tl),
      .table_entry_action      (ta),
      .table_entry_dst_mac     (tm),
      .table_entry_egress_port (tport),
      .packet_count            (pc),
      .forwarded_count         (fc),
      .dropped_count           (dc)
   );

   // output monitor: collects handshaken beats and checks stability across stalls
   always @(negedge aclk) begin
      if (stalled) begin
         checks++;
         assert (m_if.tvalid === 1'b1 && m_if.tdata === prev_d && m_if.tdest === prev_t && m_if.tlast === prev_l)
         else begin
            errors++;
            $error("FAIL stall_hold valid=%0b dest=%0d last=%0b, required valid=1 dest=%0d last=%0b and unchanged data",
                   m_if.tvalid, m_if.tdest, m_if.tlast, prev_t, prev_l);
         end
      end
      stalled <= m_if.tvalid && !m_if.tready;
      prev_d <= m_if.tdata;
      prev_t <= m_if.tdest;
      prev_l <= m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
         oq_d.push_back(m_if.tdata);
         oq_t.push_back(m_if.tdest);
         oq_l.push_back(m_if.tlast);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_counts(input string tag, input logic [31:0] p, input logic [31:0] f, input logic [31:0] d);
      chk({tag, "_pkt"}, pc, p);
      chk({tag, "_fwd"}, fc, f);
      chk({tag, "_drop"}, dc, d);
   endtask

   task automatic wr(input logic [9:0] a, input logic v, input logic [31:0] p, input logic [5:0] l,
                     input logic [2:0] act, input logic [47:0] mac, input logic [8:0] port);
      twa = a; tv = v; tp = p; tl = l; ta = act; tm = mac; tport = port; twe = 1'b1;
      tick(1);
      twe = 1'b0;
   endtask

   function automatic logic [DW-1:0] mk(input logic [31:0] ip, input logic [7:0] ttl,
                                        input logic [15:0] et, input logic [15:0] cs);
      logic [DW-1:0] d;
      d = '0;
      d[47:0] = 48'hFFFF_FFFF_FFFF;
      d[95:48] = 48'h0200_0000_0001;
      d[111:96] = et;
      d[143:112] = 32'h4500_0054;
      d[183:176] = ttl;
      d[207:192] = cs;
      d[271:240] = ip;
      d[511:480] = 32'hDEAD_BEEF;
      return d;
   endfunction

   function automatic logic [DW-1:0] fx(input logic [DW-1:0] h, input logic [47:0] mac,
                                        input logic [7:0] ttl, input logic [15:0] cs);
      logic [DW-1:0] e;
      e = h;
      e[47:0] = mac;
      e[95:48] = 48'hFFFF_FFFF_FFFF;
      e[183:176] = ttl;
      e[207:192] = cs;
      return e;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic last);
      bit done = 1'b0;
      s_if.tdata = d;
      s_if.tkeep = '1;
      s_if.tlast = last;
      s_if.tvalid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge aclk);
         if (s_if.tready) begin
            @(posedge aclk);
            done = 1'b1;
         end
      end
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      checks++;
      assert (done)
      else begin
         errors++;
         $error("FAIL send_accept ready=0 after 200 cycles, required a handshake");
      end
   endtask

   task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic [8:0] dest, input logic last);
      for (int n = 0; n < 60 && oq_d.size() == 0; n++) @(posedge aclk);
      #1;
      checks++;
      assert (oq_d.size() > 0)
      else begin
         errors++;
         $error("FAIL %s_present got 0 beats within 60 cycles, expected 1", tag);
      end
      if (oq_d.size() > 0) begin
         chk({tag, "_data"}, oq_d.pop_front(), d);
         chk({tag, "_dest"}, oq_t.pop_front(), dest);
         chk({tag, "_last"}, oq_l.pop_front(), last);
      end
   endtask

   task automatic expect_none(input string tag);
      tick(10);
      chk({tag, "_no_output"}, oq_d.size(), 0);
      oq_d.delete();
      oq_t.delete();
      oq_l.delete();
   endtask

   initial begin
      logic [DW-1:0] h, b1, b2;
      s_if.tdata = '0;
      s_if.tkeep = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      s_if.tdest = '0;
      m_if.tready = 1'b1;
      b1 = {16{32'h1111_1111}};
      b2 = {16{32'h2222_2222}};
      tick(3);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_m_tdest", m_if.tdest, 0);
      chk("rst_m_tdata", m_if.tdata, 0);
      chk_counts("rst", 0, 0, 0);
      aresetn = 1'b1;
      tick(2);
      chk("idle_s_tready", s_if.tready, 1);
      wr(10'd0, 1'b1, 32'hC0A8_0100, 6'd24, 3'd1, 48'h0011_2233_4455, 9'd1);
      wr(10'd1, 1'b1, 32'h0A00_0000, 6'd8, 3'd0, 48'h0, 9'd3);
      wr(10'd2, 1'b1, 32'hAC10_0000, 6'd12, 3'd1, 48'hAABB_CCDD_EEFF, 9'd2);
      h = mk(32'hC0A8_0164, 8'd64, 16'h0800, 16'hB1E6);
      send_beat(h, 1'b1);
      expect_out("p1_fwd24", fx(h, 48'h0011_2233_4455, 8'd63, 16'hB2E6), 9'd1, 1'b1);
      chk_counts("p1", 1, 1, 0);
      send_beat(mk(32'h0A01_0203, 8'd64, 16'h0800, 16'hB1E6), 1'b1);
      expect_none("p2_drop_action");
      chk_counts("p2", 2, 1, 1);
      h = mk(32'hAC10_050A, 8'd64, 16'h0800, 16'hFF20);
      send_beat(h, 1'b1);
      expect_out("p3_fwd12_carry", fx(h, 48'hAABB_CCDD_EEFF, 8'd63, 16'h0021), 9'd2, 1'b1);
      chk_counts("p3", 3, 2, 1);
      wr(10'd8, 1'b1, 32'h0808_0808, 6'd33, 3'd1, 48'h1234_5678_9ABC, 9'd4);
      send_beat(mk(32'h0808_0808, 8'd64, 16'h0800, 16'hB1E6), 1'b1);
      expect_none("p4_nomatch_len33");
      chk_counts("p4", 4, 2, 2);
      send_beat(mk(32'hC0A8_0164, 8'd1, 16'h0800, 16'hB1E6), 1'b1);
      expect_none("p5_ttl1");
      chk_counts("p5", 5, 2, 3);
      wr(10'd7, 1'b1, 32'hC0A8_0164, 6'd32, 3'd1, 48'h0A0B_0C0D_0E0F, 9'd5);
      h = mk(32'hC0A8_0164, 8'd64, 16'h0800, 16'hB1E6);
      send_beat(h, 1'b1);
      expect_out("p6_fwd32", fx(h, 48'h0A0B_0C0D_0E0F, 8'd63, 16'hB2E6), 9'd5, 1'b1);
      chk_counts("p6", 6, 3, 3);
      send_beat(mk(32'hC0A8_0164, 8'd64, 16'h86DD, 16'hB1E6), 1'b1);
      expect_none("p7_non_ipv4");
      chk_counts("p7", 7, 3, 4);
      h = mk(32'hAC10_0909, 8'd64, 16'h0800, 16'h1234);
      fork
         begin
            send_beat(h, 1'b0);
            send_beat(b1, 1'b0);
            send_beat(b2, 1'b1);
         end
         begin
            for (int i = 0; i < 40; i++) begin
               @(posedge aclk);
               #1;
               m_if.tready = (i % 3) != 0;
            end
            m_if.tready = 1'b1;
         end
      join
      expect_out("p8_beat0", fx(h, 48'hAABB_CCDD_EEFF, 8'd63, 16'h1334), 9'd2, 1'b0);
      expect_out("p8_beat1", b1, 9'd2, 1'b0);
      expect_out("p8_beat2", b2, 9'd2, 1'b1);
      chk_counts("p8", 8, 4, 4);
      send_beat(mk(32'h0A09_0909, 8'd64, 16'h0800, 16'hB1E6), 1'b0);
      send_beat(b1, 1'b0);
      send_beat(b2, 1'b1);
      expect_none("p9_drop_multi");
      chk_counts("p9", 9, 4, 5);
      chk("end_s_tready", s_if.tready, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
